// File: rtl/dbus_if.sv
// Data bus between the MEM stage and data memory: request/ack handshake.
// master drives req/we/sel/addr/wdata; slave returns rdata/ack.
interface dbus_if;
  logic        req;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, sel, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, sel, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: pass-through of EX results, data bus load/store with stall,
// big-endian align/extend, store lanes, misalign and bus-timeout flags.
// Ports: clk/resetn, ex_* in, mem_hold, dbus master, stallreq, mem_* out.
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_memaddr,
  input  logic [31:0] ex_memdata,
  input  logic        mem_hold,
  dbus_if.master      dbus,
  output logic        stallreq,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_adel,
  output logic        mem_ades,
  output logic        mem_buserr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam bit        TO_EN   = (ACK_TIMEOUT != 0);
  localparam bit [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  logic        req_q, we_q, err_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q, wdata_q, ldbuf;
  logic [15:0] cnt;

  logic        lb, lbu, lh, lhu, lw, sb, sh, sw;
  logic        acc_b, acc_h, acc_w, is_ld, is_st;
  logic        misal, go, in_done;
  logic [1:0]  off;
  logic [3:0]  sel_n;
  logic [31:0] wdat_n, ld_n;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign off = ex_memaddr[1:0];

  assign lb  = ex_memop == 4'd1;
  assign lbu = ex_memop == 4'd2;
  assign lh  = ex_memop == 4'd3;
  assign lhu = ex_memop == 4'd4;
  assign lw  = ex_memop == 4'd5;
  assign sb  = ex_memop == 4'd9;
  assign sh  = ex_memop == 4'd10;
  assign sw  = ex_memop == 4'd11;

  assign acc_b = lb | lbu | sb;
  assign acc_h = lh | lhu | sh;
  assign acc_w = lw | sw;
  assign is_ld = lb | lbu | lh | lhu | lw;
  assign is_st = sb | sh | sw;

  assign misal = (acc_h & off[0]) | (acc_w & (off != 2'b00));
  assign go    = (is_ld | is_st) & ~misal;

  always_comb begin
    sel_n  = 4'b0000;
    wdat_n = ex_memdata;
    unique case (1'b1)
      acc_b: begin
        sel_n  = 4'b1000 >> off;
        wdat_n = {4{ex_memdata[7:0]}};
      end
      acc_h: begin
        sel_n  = off[1] ? 4'b0011 : 4'b1100;
        wdat_n = {2{ex_memdata[15:0]}};
      end
      acc_w: sel_n = 4'b1111;
      default: ;
    endcase
  end

  // Big-endian: offset 0 is the most significant byte/half.
  always_comb begin
    byte_v = dbus.rdata[31:24];
    unique case (off)
      2'd0: byte_v = dbus.rdata[31:24];
      2'd1: byte_v = dbus.rdata[23:16];
      2'd2: byte_v = dbus.rdata[15:8];
      2'd3: byte_v = dbus.rdata[7:0];
      default: ;
    endcase
  end

  assign half_v = off[1] ? dbus.rdata[15:0] : dbus.rdata[31:16];

  always_comb begin
    ld_n = 32'h0;
    unique case (1'b1)
      lb:  ld_n = {{24{byte_v[7]}}, byte_v};
      lbu: ld_n = {24'h0, byte_v};
      lh:  ld_n = {{16{half_v[15]}}, half_v};
      lhu: ld_n = {16'h0, half_v};
      lw:  ld_n = dbus.rdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ldbuf   <= 32'h0;
      cnt     <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (go) begin
          state   <= BUSY;
          req_q   <= 1'b1;
          we_q    <= is_st;
          sel_q   <= sel_n;
          addr_q  <= {ex_memaddr[31:2], 2'b00};
          wdata_q <= wdat_n;
          cnt     <= 16'h0;
          err_q   <= 1'b0;
        end
        BUSY: begin
          cnt <= cnt + 16'd1;
          // An ack in the last allowed cycle still completes normally.
          if (dbus.ack) begin
            ldbuf <= is_ld ? ld_n : 32'h0;
            req_q <= 1'b0;
            state <= DONE;
          end else if (TO_EN && cnt == TO_LAST) begin
            err_q <= 1'b1;
            req_q <= 1'b0;
            state <= DONE;
          end
        end
        DONE: if (!mem_hold) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dbus.req   = req_q;
  assign dbus.we    = we_q;
  assign dbus.sel   = sel_q;
  assign dbus.addr  = addr_q;
  assign dbus.wdata = wdata_q;

  assign in_done  = state == DONE;
  assign stallreq = ((state == IDLE) & go) | (state == BUSY);

  assign mem_adel   = is_ld & misal;
  assign mem_ades   = is_st & misal;
  assign mem_buserr = in_done & err_q;

  assign mem_wdata = (in_done & is_ld) ? ldbuf : ex_wdata;
  assign mem_wd    = ex_wd;
  assign mem_hi    = ex_hi;
  assign mem_lo    = ex_lo;
  assign mem_wreg  = ex_wreg & ~misal & ~stallreq & ~mem_buserr;
  assign mem_whilo = ex_whilo & ~stallreq;

endmodule
